hdma_engine: RTL and testbench
==============================

Name: hdma_engine

Overview:
- CGB HDMA/GDMA controller: the writer side of the VRAM port consumed by the gb top's video/VRAM block.
- Copies 16-byte blocks from a 16-bit source address space into the 8 KB VRAM window by driving vram_addr/vram_wren/vram_di.
- Supports two modes: general-purpose (whole transfer at once, CPU stalled) and HBlank (one block per HBlank, paced by lcd_mode).
- Sits beside video in the gb top and shares the cpu_sel_reg/cpu_addr register bus.

Parameters:
- BLOCK_BYTES, 16, bytes per block; must be a power of two.

Ports:
- clk_sys  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- ce  in  1  CPU-speed clock enable; all state advances only when ce=1
- isGBC  in  1  0: block disabled (writes ignored, register reads 8'hFF)
- cpu_sel_reg  in  1  register bus select
- cpu_addr  in  8  register offset; responds to 8'h51..8'h55
- cpu_wr  in  1  register write strobe
- cpu_di  in  8  write data
- cpu_do  out  8  read data
- lcd_on  in  1  LCD enable
- lcd_mode  in  2  PPU mode; 0 = HBlank
- dma_rd  out  1  source read strobe
- dma_addr  out  16  source address
- dma_data  in  8  source data, valid one ce-cycle after dma_rd
- vram_wren  out  1  VRAM write strobe
- vram_addr  out  13  VRAM address
- vram_di  out  8  VRAM write data
- cpu_stall  out  1  halts CPU while a block is moving

Behaviour:
- Registers:
  - 51 = SRC_HI; 52 = SRC_LO, bits [3:0] forced 0.
  - 53 = DST_HI, bits [4:0] kept; 54 = DST_LO, bits [3:0] forced 0.
  - Reads of 51..54 return 8'hFF.
  - Read of 55 returns {~active, remaining[6:0]}. It returns 8'hFF after completion and after reset.
- Write to 55:
  - Bit7=0 while idle: start GDMA with length = cpu_di[6:0]+1 blocks.
  - Bit7=1 while idle: start HDMA with the same length.
  - Start copies SRC/DST into working counters. Later writes to 51..54 do not affect an active transfer.
  - Bit7=0 while HDMA active: cancel. The engine finishes the current block if one is in flight, then goes idle. Reads then show {1, remaining}.
  - Bit7=1 while HDMA active: reload remaining with cpu_di[6:0] and continue.
  - Bit7=0 while GDMA active: impossible, because the CPU is stalled.
- States: IDLE, RD, WR, HB_WAIT, HB_HOLD.
  - RD: dma_rd=1, dma_addr=src.
  - WR (next ce): vram_wren=1, vram_addr=dst, vram_di=dma_data. Then src+1 (16-bit wrap) and dst+1 (13-bit wrap 1FFF→0000).
  - Each byte costs 2 ce cycles, so one block costs 32 ce cycles.
  - After the 16th byte: remaining-1.
    - If the transfer is done (remaining was 0), go to IDLE.
    - Otherwise GDMA goes back to RD, and HDMA goes to HB_HOLD.
- HDMA pacing:
  - Start goes to HB_WAIT.
  - HB_WAIT→RD on the first ce-cycle where lcd_mode==0 and the previous sampled mode !=0.
  - If lcd_on=0 at start, the first block runs immediately.
  - HB_HOLD→HB_WAIT once lcd_mode!=0, so there is exactly one block per HBlank.
  - If lcd_on falls during HB_WAIT, the engine stays in HB_WAIT.
- cpu_stall = 1 in RD/WR; 0 in IDLE/HB_WAIT/HB_HOLD.
- Outputs are registered. Strobes are held no longer than one ce-cycle.
- Reset:
  - State IDLE; all counters and registers 0; remaining=7'h7F with active=0 (reads 8'hFF).
  - dma_rd, vram_wren and cpu_stall are 0.
  - Reset mid-transfer aborts with no further writes.
- isGBC=0 forces IDLE and suppresses all strobes.

Test Plan:
- GDMA, 1 block: SRC=C000, DST=8000 (53=00,54=00), source holds 00..0F, write 55←00 → 16 VRAM writes to 0000..000F with data 00..0F; cpu_stall high exactly 32 ce-cycles; 55 reads FF afterward.
- Low-nibble masking and wrap: 52←3F, 53←FF, 54←F7, 55←01 → SRC=xx30, DST=1FF0; 2 blocks; second block writes 0000..000F.
- HDMA, 3 blocks: 55←82, lcd_mode cycles 2→3→0 three times → one 16-byte burst per mode-0 entry only, none while mode 0 is held; 55 reads 01 then 00 between bursts, then FF.
- Cancel: 55←85, after the first HBlank burst write 55←00 → no further writes on later HBlanks; 55 reads 84.
- Cancel mid-block and LCD off: lcd_on=0, 55←81 → block 1 starts immediately; 55←00 during byte 5 → bytes 6..16 still written, then IDLE.
- Reset: reset_n low during WR of byte 3 → strobes drop asynchronously; after release 55 reads FF and no writes occur.

Source files
------------

// File: rtl/hdma_if.sv
// rtl/hdma_if.sv - Register bus, source-read port and VRAM-write port of the CGB HDMA engine.
interface hdma_if;
  logic        cpu_sel_reg;
  logic [7:0]  cpu_addr;
  logic        cpu_wr;
  logic [7:0]  cpu_di;
  logic [7:0]  cpu_do;
  logic        cpu_stall;
  logic        dma_rd;
  logic [15:0] dma_addr;
  logic [7:0]  dma_data;
  logic        vram_wren;
  logic [12:0] vram_addr;
  logic [7:0]  vram_di;

  modport master (
    input  cpu_sel_reg, cpu_addr, cpu_wr, cpu_di, dma_data,
    output cpu_do, cpu_stall, dma_rd, dma_addr, vram_wren, vram_addr, vram_di
  );

  modport slave (
    output cpu_sel_reg, cpu_addr, cpu_wr, cpu_di, dma_data,
    input  cpu_do, cpu_stall, dma_rd, dma_addr, vram_wren, vram_addr, vram_di
  );
endinterface

// File: rtl/hdma_engine.sv
// rtl/hdma_engine.sv - CGB general-purpose / HBlank DMA engine feeding the VRAM write port.
module hdma_engine #(
  parameter int BLOCK_BYTES = 16
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       ce,
  input  logic       isGBC,
  input  logic       lcd_on,
  input  logic [1:0] lcd_mode,
  hdma_if.master     bus
);

  localparam int            CW       = (BLOCK_BYTES > 1) ? $clog2(BLOCK_BYTES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BLOCK_BYTES - 1);
  localparam logic [7:0]    LO_MASK  = 8'(~(BLOCK_BYTES - 1));

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WR,
    S_HB_WAIT,
    S_HB_HOLD
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] src_reg_q, src_reg_d;
  logic [12:0] dst_reg_q, dst_reg_d;
  logic [15:0] src_q, src_d;
  logic [12:0] dst_q, dst_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [6:0]  remaining_q, remaining_d;
  logic        active_q, active_d;
  logic        hdma_q, hdma_d;
  logic        cancel_q, cancel_d;
  logic [1:0]  prev_mode_q, prev_mode_d;
  logic        dma_rd_q, dma_rd_d;
  logic [15:0] dma_addr_q, dma_addr_d;
  logic        vram_wren_q, vram_wren_d;
  logic [12:0] vram_addr_q, vram_addr_d;
  logic        cpu_stall_q, cpu_stall_d;

  logic reg_wr;
  assign reg_wr = bus.cpu_sel_reg & bus.cpu_wr & isGBC & ce;

  always_comb begin
    state_d     = state_q;
    src_reg_d   = src_reg_q;
    dst_reg_d   = dst_reg_q;
    src_d       = src_q;
    dst_d       = dst_q;
    cnt_d       = cnt_q;
    remaining_d = remaining_q;
    active_d    = active_q;
    hdma_d      = hdma_q;
    cancel_d    = cancel_q;
    prev_mode_d = prev_mode_q;

    if (ce) begin
      prev_mode_d = lcd_mode;

      case (state_q)
        S_RD: state_d = S_WR;
        S_WR: begin
          src_d   = src_q + 16'd1;
          dst_d   = dst_q + 13'd1;
          cnt_d   = cnt_q + CW'(1);
          state_d = S_RD;
          if (cnt_q == CNT_LAST) begin
            remaining_d = remaining_q - 7'd1;
            if (remaining_q == 7'd0 || cancel_q) begin
              state_d  = S_IDLE;
              active_d = 1'b0;
              cancel_d = 1'b0;
            end else if (hdma_q) begin
              state_d = S_HB_HOLD;
            end
          end
        end
        // A burst starts only on entry into HBlank with the LCD running.
        S_HB_WAIT: begin
          if (lcd_on && lcd_mode == 2'd0 && prev_mode_q != 2'd0) begin
            state_d = S_RD;
          end
        end
        S_HB_HOLD: begin
          if (lcd_mode != 2'd0) begin
            state_d = S_HB_WAIT;
          end
        end
        default: ;
      endcase

      if (reg_wr) begin
        case (bus.cpu_addr)
          8'h51: src_reg_d[15:8] = bus.cpu_di;
          8'h52: src_reg_d[7:0]  = bus.cpu_di & LO_MASK;
          8'h53: dst_reg_d[12:8] = bus.cpu_di[4:0];
          8'h54: dst_reg_d[7:0]  = bus.cpu_di & LO_MASK;
          8'h55: begin
            if (!active_q) begin
              remaining_d = bus.cpu_di[6:0];
              active_d    = 1'b1;
              hdma_d      = bus.cpu_di[7];
              cancel_d    = 1'b0;
              src_d       = src_reg_q;
              dst_d       = dst_reg_q;
              cnt_d       = '0;
              state_d     = (bus.cpu_di[7] && lcd_on) ? S_HB_WAIT : S_RD;
            end else if (hdma_q) begin
              if (bus.cpu_di[7]) begin
                remaining_d = bus.cpu_di[6:0];
                cancel_d    = 1'b0;
                if (state_d == S_IDLE) begin
                  state_d  = S_HB_HOLD;
                  active_d = 1'b1;
                end
              end else if (state_q == S_RD || state_q == S_WR) begin
                // The block in flight completes before the engine stops.
                if (state_d != S_IDLE) begin
                  cancel_d = 1'b1;
                end
              end else begin
                state_d  = S_IDLE;
                active_d = 1'b0;
              end
            end
          end
          default: ;
        endcase
      end
    end

    if (!isGBC) begin
      state_d  = S_IDLE;
      active_d = 1'b0;
      cancel_d = 1'b0;
    end

    dma_rd_d    = (state_d == S_RD);
    dma_addr_d  = src_d;
    vram_wren_d = (state_d == S_WR);
    vram_addr_d = dst_d;
    cpu_stall_d = (state_d == S_RD) || (state_d == S_WR);
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      src_reg_q   <= '0;
      dst_reg_q   <= '0;
      src_q       <= '0;
      dst_q       <= '0;
      cnt_q       <= '0;
      remaining_q <= 7'h7F;
      active_q    <= 1'b0;
      hdma_q      <= 1'b0;
      cancel_q    <= 1'b0;
      prev_mode_q <= '0;
      dma_rd_q    <= 1'b0;
      dma_addr_q  <= '0;
      vram_wren_q <= 1'b0;
      vram_addr_q <= '0;
      cpu_stall_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      src_reg_q   <= src_reg_d;
      dst_reg_q   <= dst_reg_d;
      src_q       <= src_d;
      dst_q       <= dst_d;
      cnt_q       <= cnt_d;
      remaining_q <= remaining_d;
      active_q    <= active_d;
      hdma_q      <= hdma_d;
      cancel_q    <= cancel_d;
      prev_mode_q <= prev_mode_d;
      dma_rd_q    <= dma_rd_d;
      dma_addr_q  <= dma_addr_d;
      vram_wren_q <= vram_wren_d;
      vram_addr_q <= vram_addr_d;
      cpu_stall_q <= cpu_stall_d;
    end
  end

  assign bus.dma_rd    = dma_rd_q;
  assign bus.dma_addr  = dma_addr_q;
  assign bus.vram_wren = vram_wren_q;
  assign bus.vram_addr = vram_addr_q;
  assign bus.cpu_stall = cpu_stall_q;
  // The source returns its byte during the write cycle, so it is forwarded as-is.
  assign bus.vram_di   = bus.dma_data;
  assign bus.cpu_do    = (isGBC && bus.cpu_sel_reg && bus.cpu_addr == 8'h55) ?
                         {~active_q, remaining_q} : 8'hFF;

endmodule

// File: tb/tb_hdma_engine.sv
// tb/tb_hdma_engine.sv - Self-checking bench for hdma_engine against a block-copy reference model.
module tb_hdma_engine;
  logic       clk_sys = 1'b0;
  logic       reset_n;
  logic       ce;
  logic       ce_rand;
  logic       isGBC;
  logic       lcd_on;
  logic [1:0] lcd_mode;
  int         total;
  int         bad;
  int         stall_cnt = 0;
  logic [7:0]  mem [65536];
  logic [20:0] wlog [$];
  logic [20:0] eq [$];

  hdma_if bus ();

  hdma_engine #(.BLOCK_BYTES(16)) dut (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .ce      (ce),
    .isGBC   (isGBC),
    .lcd_on  (lcd_on),
    .lcd_mode(lcd_mode),
    .bus     (bus)
  );

  always #5 clk_sys = ~clk_sys;

  initial begin
    ce = 1'b1;
    forever begin
      @(negedge clk_sys);
      ce = ce_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  always @(posedge clk_sys) begin
    if (reset_n && ce) begin
      if (bus.vram_wren) wlog.push_back({bus.vram_addr, bus.vram_di});
      if (bus.cpu_stall) stall_cnt++;
    end
  end

  always @(posedge clk_sys) begin
    if (reset_n && ce && bus.dma_rd) bus.dma_data <= mem[bus.dma_addr];
  end

  initial begin
    #900000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic reg_wr(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk_sys);
    bus.cpu_sel_reg = 1'b1;
    bus.cpu_wr      = 1'b1;
    bus.cpu_addr    = a;
    bus.cpu_di      = d;
    @(posedge clk_sys);
    while (!ce) @(posedge clk_sys);
    #1;
    bus.cpu_sel_reg = 1'b0;
    bus.cpu_wr      = 1'b0;
  endtask

  task automatic reg_rd(input logic [7:0] a, output logic [7:0] d);
    @(negedge clk_sys);
    bus.cpu_sel_reg = 1'b1;
    bus.cpu_wr      = 1'b0;
    bus.cpu_addr    = a;
    #1 d = bus.cpu_do;
    bus.cpu_sel_reg = 1'b0;
  endtask

  task automatic ce_cycles(input int n);
    int k = 0;
    while (k < n) begin
      @(posedge clk_sys);
      if (ce) k++;
    end
    #1;
  endtask

  task automatic wait_idle(input string tag);
    logic [7:0] r;
    int n = 0;
    reg_rd(8'h55, r);
    while (!r[7] && n < 3000) begin
      reg_rd(8'h55, r);
      n++;
    end
    check({tag, "_timeout"}, 32'(n >= 3000), 32'd0);
  endtask

  task automatic wait_writes(input int base, input int target, input string tag);
    int n = 0;
    while (wlog.size() - base < target && n < 3000) begin
      @(negedge clk_sys);
      n++;
    end
    check({tag, "_timeout"}, 32'(n >= 3000), 32'd0);
  endtask

  task automatic hblank();
    lcd_mode = 2'd2;
    ce_cycles(8);
    lcd_mode = 2'd3;
    ce_cycles(8);
    lcd_mode = 2'd0;
    ce_cycles(80);
  endtask

  // Reference: block b byte i goes from src+16b+i (mod 64K) to dst+16b+i (mod 8K).
  task automatic expect_blocks(input logic [15:0] src, input logic [12:0] dst, input int nblk);
    for (int b = 0; b < nblk; b++) begin
      for (int i = 0; i < 16; i++) begin
        int off;
        int sa;
        int da;
        off = 16 * b + i;
        sa  = (int'(src) + off) % 65536;
        da  = (int'(dst) + off) % 8192;
        eq.push_back({13'(da), mem[sa]});
      end
    end
  endtask

  task automatic compare_writes(input int base, input string tag);
    check({tag, "_count"}, 32'(wlog.size() - base), 32'(eq.size()));
    for (int i = 0; i < eq.size() && base + i < wlog.size(); i++) begin
      check({tag, "_write"}, 32'(wlog[base + i]), 32'(eq[i]));
    end
    eq.delete();
  endtask

  task automatic set_regs(output logic [15:0] src, output logic [12:0] dst);
    logic [7:0] hi, lo, dhi, dlo;
    hi  = 8'($urandom);
    lo  = 8'($urandom);
    dhi = 8'($urandom);
    dlo = 8'($urandom);
    reg_wr(8'h51, hi);
    reg_wr(8'h52, lo);
    reg_wr(8'h53, dhi);
    reg_wr(8'h54, dlo);
    src = {hi, lo[7:4], 4'h0};
    dst = {dhi[4:0], dlo[7:4], 4'h0};
  endtask

  initial begin
    logic [7:0]  r;
    logic [7:0]  hi;
    logic [15:0] src;
    logic [12:0] dst;
    int          base;
    int          st0;
    int          nb;
    int          n;

    total = 0;
    bad   = 0;
    ce_rand  = 1'b0;
    reset_n  = 1'b0;
    isGBC    = 1'b1;
    lcd_on   = 1'b1;
    lcd_mode = 2'd2;
    bus.cpu_sel_reg = 1'b0;
    bus.cpu_wr      = 1'b0;
    bus.cpu_addr    = 8'h00;
    bus.cpu_di      = 8'h00;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    for (int i = 0; i < 16; i++) mem[16'hC000 + i] = 8'(i);

    repeat (3) @(negedge clk_sys);
    check("rst_dma_rd", 32'(bus.dma_rd), 32'd0);
    check("rst_vram_wren", 32'(bus.vram_wren), 32'd0);
    check("rst_cpu_stall", 32'(bus.cpu_stall), 32'd0);
    reset_n = 1'b1;
    reg_rd(8'h55, r);
    check("rst_reg55", 32'(r), 32'hFF);

    // GDMA, one block, fixed pattern
    reg_wr(8'h51, 8'hC0);
    reg_wr(8'h52, 8'h00);
    reg_wr(8'h53, 8'h00);
    reg_wr(8'h54, 8'h00);
    reg_rd(8'h51, r);
    check("reg51_read", 32'(r), 32'hFF);
    base = wlog.size();
    st0  = stall_cnt;
    expect_blocks(16'hC000, 13'h0000, 1);
    reg_wr(8'h55, 8'h00);
    wait_idle("gdma1");
    check("gdma1_stall_cycles", 32'(stall_cnt - st0), 32'd32);
    compare_writes(base, "gdma1");
    reg_rd(8'h55, r);
    check("gdma1_reg55", 32'(r), 32'hFF);

    // Low-nibble masking and 13-bit destination wrap
    ce_rand = 1'b1;
    hi = 8'($urandom);
    reg_wr(8'h51, hi);
    reg_wr(8'h52, 8'h3F);
    reg_wr(8'h53, 8'hFF);
    reg_wr(8'h54, 8'hF7);
    base = wlog.size();
    expect_blocks({hi, 8'h30}, 13'h1FF0, 2);
    reg_wr(8'h55, 8'h01);
    wait_idle("wrap");
    check("wrap_addr", (wlog.size() > base + 16) ? 32'(wlog[base + 16][20:8]) : 32'hDEAD, 32'd0);
    compare_writes(base, "wrap");

    // Random GDMA transfers
    for (int t = 0; t < 4; t++) begin
      set_regs(src, dst);
      nb = $urandom_range(1, 4);
      base = wlog.size();
      st0  = stall_cnt;
      expect_blocks(src, dst, nb);
      reg_wr(8'h55, 8'(nb - 1));
      wait_idle("rgdma");
      check("rgdma_stall_cycles", 32'(stall_cnt - st0), 32'(32 * nb));
      compare_writes(base, "rgdma");
    end

    // Block disabled
    isGBC = 1'b0;
    reg_rd(8'h55, r);
    check("nogbc_reg55", 32'(r), 32'hFF);
    base = wlog.size();
    reg_wr(8'h55, 8'h00);
    ce_cycles(50);
    check("nogbc_writes", 32'(wlog.size() - base), 32'd0);
    check("nogbc_stall", 32'(bus.cpu_stall), 32'd0);
    isGBC = 1'b1;

    // HDMA, three blocks paced by HBlank
    lcd_on   = 1'b1;
    lcd_mode = 2'd2;
    set_regs(src, dst);
    base = wlog.size();
    expect_blocks(src, dst, 3);
    reg_wr(8'h55, 8'h82);
    ce_cycles(20);
    check("hdma_wait_writes", 32'(wlog.size() - base), 32'd0);
    for (int k = 0; k < 3; k++) begin
      hblank();
      check("hdma_burst_writes", 32'(wlog.size() - base), 32'(16 * (k + 1)));
      reg_rd(8'h55, r);
      check("hdma_reg55", 32'(r), (k == 0) ? 32'h01 : (k == 1) ? 32'h00 : 32'hFF);
      if (k == 0) begin
        reg_wr(8'h51, 8'($urandom));
        reg_wr(8'h52, 8'($urandom));
        reg_wr(8'h53, 8'($urandom));
        reg_wr(8'h54, 8'($urandom));
      end
    end
    hblank();
    compare_writes(base, "hdma3");

    // HDMA cancel between HBlanks
    set_regs(src, dst);
    base = wlog.size();
    expect_blocks(src, dst, 1);
    reg_wr(8'h55, 8'h85);
    hblank();
    reg_wr(8'h55, 8'h00);
    reg_rd(8'h55, r);
    check("cancel_reg55", 32'(r), 32'h84);
    hblank();
    hblank();
    compare_writes(base, "cancel");
    reg_rd(8'h55, r);
    check("cancel_reg55_late", 32'(r), 32'h84);

    // LCD off: first block immediate, cancel during byte 5
    ce_rand  = 1'b0;
    lcd_on   = 1'b0;
    lcd_mode = 2'd0;
    set_regs(src, dst);
    base = wlog.size();
    expect_blocks(src, dst, 1);
    reg_wr(8'h55, 8'h81);
    wait_writes(base, 4, "mid");
    reg_wr(8'h55, 8'h00);
    wait_idle("mid");
    ce_cycles(60);
    compare_writes(base, "mid");
    reg_rd(8'h55, r);
    check("mid_reg55", 32'(r), 32'h80);
    check("mid_stall", 32'(bus.cpu_stall), 32'd0);
    lcd_on = 1'b1;

    // Reset during the write of byte 3
    set_regs(src, dst);
    base = wlog.size();
    reg_wr(8'h55, 8'h01);
    n = 0;
    while (!((wlog.size() - base == 2) && bus.vram_wren) && n < 3000) begin
      @(negedge clk_sys);
      n++;
    end
    check("rstmid_timeout", 32'(n >= 3000), 32'd0);
    reset_n = 1'b0;
    #1;
    check("rstmid_vram_wren", 32'(bus.vram_wren), 32'd0);
    check("rstmid_dma_rd", 32'(bus.dma_rd), 32'd0);
    check("rstmid_cpu_stall", 32'(bus.cpu_stall), 32'd0);
    repeat (3) @(negedge clk_sys);
    reset_n = 1'b1;
    ce_cycles(100);
    check("rstmid_writes", 32'(wlog.size() - base), 32'd2);
    reg_rd(8'h55, r);
    check("rstmid_reg55", 32'(r), 32'hFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
